// File: rtl/da_row_collector.sv
// Output collector for the bit-serial DA array. It tracks the array's bit and row counters,
// captures each finished row, requantises it, and queues it for a valid/ready consumer.
module da_row_collector #(
    parameter int unsigned DATA_WIDTH_A = 8,
    parameter int unsigned M            = 2,
    parameter int unsigned N            = 4,
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter int unsigned SHIFT        = 0,
    parameter int unsigned RELU_EN      = 0,
    parameter int unsigned CAP_LAT      = 1,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            gen_done,
    input  logic [N-1:0][IN_WIDTH-1:0]      final_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N-1:0][OUT_WIDTH-1:0]     out_row,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row_idx,
    output logic                            out_last,
    output logic                            stall,
    output logic                            overflow
);
    localparam int unsigned T_W = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
    localparam int unsigned M_W = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned A_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned C_W = A_W + 1;
    localparam int unsigned X_W = IN_WIDTH + 1;
    localparam int unsigned S_W = (X_W > OUT_WIDTH) ? X_W : OUT_WIDTH;

    localparam logic [X_W-1:0]        RND  = X_W'((2 ** SHIFT) >> 1);
    localparam logic signed [S_W-1:0] MAXV = S_W'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
    localparam logic signed [S_W-1:0] MINV = ~MAXV;

    // Bit-plane and kernel-row counters mirrored from the array.
    logic [T_W-1:0] t_q;
    logic [M_W-1:0] m_q;
    logic           wrap_c;

    assign wrap_c = gen_done && (t_q == T_W'(DATA_WIDTH_A - 1));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            t_q <= '0;
            m_q <= '0;
        end else if (gen_done) begin
            if (wrap_c) begin
                t_q <= '0;
                m_q <= (m_q == M_W'(M - 1)) ? '0 : M_W'(m_q + M_W'(1));
            end else begin
                t_q <= T_W'(t_q + T_W'(1));
            end
        end
    end

    // Capture tokens wait out the array's result latency.
    logic [CAP_LAT-1:0] pipe_vld;
    logic [M_W-1:0]     pipe_idx [CAP_LAT];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < CAP_LAT; i++) pipe_idx[i] <= '0;
        end else begin
            pipe_vld[0] <= wrap_c;
            pipe_idx[0] <= m_q;
            for (int unsigned i = 1; i < CAP_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    function automatic logic [OUT_WIDTH-1:0] requant(input logic [IN_WIDTH-1:0] x);
        logic signed [X_W-1:0] v;
        logic signed [S_W-1:0] s;
        v = {x[IN_WIDTH-1], x};
        v = v + RND;
        v = v >>> SHIFT;
        if ((RELU_EN != 0) && v[X_W-1]) v = '0;
        s = S_W'(v);
        if (s > MAXV)      s = MAXV;
        else if (s < MINV) s = MINV;
        return OUT_WIDTH'(s);
    endfunction

    logic [N-1:0][OUT_WIDTH-1:0] row_c;

    always_comb begin
        row_c = '0;
        for (int unsigned i = 0; i < N; i++) row_c[i] = requant(final_out[i]);
    end

    // Row FIFO: requantised data plus kernel row index.
    logic [N-1:0][OUT_WIDTH-1:0] mem_row [DEPTH];
    logic [M_W-1:0]              mem_idx [DEPTH];
    logic [A_W-1:0]              wr_ptr;
    logic [A_W-1:0]              rd_ptr;
    logic [C_W-1:0]              cnt;
    logic [C_W-1:0]              cnt_nxt_c;
    logic                        push_c;
    logic                        pop_c;
    logic                        full_c;
    logic                        acc_c;
    logic                        drop_c;

    assign push_c    = pipe_vld[CAP_LAT-1] && !flush;
    assign pop_c     = out_valid && out_ready;
    assign full_c    = (cnt == C_W'(DEPTH));
    assign acc_c     = push_c && (!full_c || pop_c);
    assign drop_c    = push_c && full_c && !pop_c;
    assign cnt_nxt_c = C_W'(cnt + C_W'(acc_c) - C_W'(pop_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            stall     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_row[i] <= '0;
                mem_idx[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            stall     <= 1'b0;
        end else begin
            if (acc_c) begin
                mem_row[wr_ptr] <= row_c;
                mem_idx[wr_ptr] <= pipe_idx[CAP_LAT-1];
                wr_ptr          <= A_W'(wr_ptr + A_W'(1));
            end
            if (pop_c) rd_ptr <= A_W'(rd_ptr + A_W'(1));
            cnt       <= cnt_nxt_c;
            out_valid <= (cnt_nxt_c != '0);
            stall     <= (cnt_nxt_c >= C_W'(DEPTH - 1));
        end
    end

    // Sticky drop flag survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)         overflow <= 1'b0;
        else if (drop_c) overflow <= 1'b1;
    end

    assign out_row     = mem_row[rd_ptr];
    assign out_row_idx = mem_idx[rd_ptr];
    assign out_last    = out_valid && (mem_idx[rd_ptr] == M_W'(M - 1));

endmodule

// File: tb/tb_da_row_collector.sv
// Directed bench for da_row_collector: capture timing, requantisation variants,
// backpressure/overflow, reset mid-row and flush of an in-flight capture.
module tb_da_row_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, gen_done, out_ready;
    logic [3:0][7:0]  fo8;
    logic [3:0][11:0] fo12;

    logic        vld   [5];
    logic [31:0] row   [5];
    logic        idx   [5];
    logic        last  [5];
    logic        stl   [5];
    logic        ovf   [5];

    int checks = 0;
    int errors = 0;

    da_row_collector u0 (
        .clk(clk), .rst(rst), .flush(flush), .gen_done(gen_done), .final_out(fo8),
        .out_valid(vld[0]), .out_ready(out_ready), .out_row(row[0]), .out_row_idx(idx[0]),
        .out_last(last[0]), .stall(stl[0]), .overflow(ovf[0]));

    da_row_collector #(.RELU_EN(1), .SHIFT(2)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .gen_done(gen_done), .final_out(fo8),
        .out_valid(vld[1]), .out_ready(out_ready), .out_row(row[1]), .out_row_idx(idx[1]),
        .out_last(last[1]), .stall(stl[1]), .overflow(ovf[1]));

    da_row_collector #(.SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .gen_done(gen_done), .final_out(fo8),
        .out_valid(vld[2]), .out_ready(out_ready), .out_row(row[2]), .out_row_idx(idx[2]),
        .out_last(last[2]), .stall(stl[2]), .overflow(ovf[2]));

    da_row_collector #(.IN_WIDTH(12)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .gen_done(gen_done), .final_out(fo12),
        .out_valid(vld[3]), .out_ready(out_ready), .out_row(row[3]), .out_row_idx(idx[3]),
        .out_last(last[3]), .stall(stl[3]), .overflow(ovf[3]));

    da_row_collector #(.CAP_LAT(3)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .gen_done(gen_done), .final_out(fo8),
        .out_valid(vld[4]), .out_ready(out_ready), .out_row(row[4]), .out_row_idx(idx[4]),
        .out_last(last[4]), .stall(stl[4]), .overflow(ovf[4]));

    function automatic logic [31:0] r8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [47:0] r12(input int a, input int b, input int c, input int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        gen_done = 1'b1;
        repeat (n) step();
        gen_done = 1'b0;
    endtask

    task automatic rst_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; gen_done = 1'b0; out_ready = 1'b0;
        fo8 = '0; fo12 = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_valid", 64'(vld[0]), 64'd0);
        chk("rst_row", 64'(row[0]), 64'd0);
        chk("rst_idx", 64'(idx[0]), 64'd0);
        chk("rst_last", 64'(last[0]), 64'd0);
        chk("rst_stall", 64'(stl[0]), 64'd0);
        chk("rst_ovf", 64'(ovf[0]), 64'd0);

        // Basic capture: two rows, idx 0 then idx 1 (last)
        fo8 = r8(5, -3, 127, -128);
        pulses(8);
        chk("basic_not_yet", 64'(vld[0]), 64'd0);
        step();
        chk("basic0_valid", 64'(vld[0]), 64'd1);
        chk("basic0_row", 64'(row[0]), 64'(r8(5, -3, 127, -128)));
        chk("basic0_idx", 64'(idx[0]), 64'd0);
        chk("basic0_last", 64'(last[0]), 64'd0);
        fo8 = r8(1, 2, 3, 4);
        pulses(8);
        step();
        chk("basic_hold_row", 64'(row[0]), 64'(r8(5, -3, 127, -128)));
        pop_one();
        chk("basic1_valid", 64'(vld[0]), 64'd1);
        chk("basic1_row", 64'(row[0]), 64'(r8(1, 2, 3, 4)));
        chk("basic1_idx", 64'(idx[0]), 64'd1);
        chk("basic1_last", 64'(last[0]), 64'd1);
        pop_one();
        chk("basic_empty", 64'(vld[0]), 64'd0);

        // Rounding, ReLU and saturation
        rst_all();
        fo8 = r8(6, -6, 9, 1);
        fo12 = r12(300, -300, 127, -129);
        pulses(8);
        step(); step();
        chk("relu_row", 64'(row[1]), 64'(r8(2, 0, 2, 0)));
        chk("round_row", 64'(row[2]), 64'(r8(2, -1, 2, 0)));
        chk("sat_valid", 64'(vld[3]), 64'd1);
        chk("sat_row", 64'(row[3]), 64'(r8(127, -128, 127, -128)));
        chk("passthru_row", 64'(row[0]), 64'(r8(6, -6, 9, 1)));

        // Backpressure: five rows into a four-deep FIFO
        rst_all();
        for (int i = 0; i < 5; i++) begin
            pulses(8);
            step();
            chk($sformatf("bp_stall%0d", i), 64'(stl[0]), 64'(i >= 2));
            chk($sformatf("bp_ovf%0d", i), 64'(ovf[0]), 64'(i == 4));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_valid%0d", k), 64'(vld[0]), 64'd1);
            chk($sformatf("drain_idx%0d", k), 64'(idx[0]), 64'(k % 2));
            step();
        end
        chk("drain_empty", 64'(vld[0]), 64'd0);
        chk("drain_ovf_sticky", 64'(ovf[0]), 64'd1);
        out_ready = 1'b0;

        // Push into a full FIFO with a same-cycle pop is accepted
        rst_all();
        for (int i = 0; i < 4; i++) begin
            pulses(8);
            step();
        end
        chk("full_stall", 64'(stl[0]), 64'd1);
        pulses(8);
        pop_one();
        chk("pushpop_ovf", 64'(ovf[0]), 64'd0);
        chk("pushpop_stall", 64'(stl[0]), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp_idx%0d", k), 64'(idx[0]), 64'((k + 1) % 2));
            step();
        end
        chk("pp_empty", 64'(vld[0]), 64'd0);
        out_ready = 1'b0;

        // Reset mid-row discards the partial bit count
        rst_all();
        pulses(3);
        rst_all();
        pulses(7);
        step(); step();
        chk("midrst_none", 64'(vld[0]), 64'd0);
        pulses(1);
        step();
        chk("midrst_valid", 64'(vld[0]), 64'd1);
        chk("midrst_idx", 64'(idx[0]), 64'd0);
        pop_one();
        chk("midrst_single", 64'(vld[0]), 64'd0);

        // Flush drops an in-flight capture token
        rst_all();
        pulses(8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (5) step();
        chk("flush_lat3_valid", 64'(vld[4]), 64'd0);
        chk("flush_lat3_ovf", 64'(ovf[4]), 64'd0);
        chk("flush_lat1_valid", 64'(vld[0]), 64'd0);
        pulses(8);
        repeat (4) step();
        chk("post_flush_valid", 64'(vld[4]), 64'd1);
        chk("post_flush_idx", 64'(idx[4]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
